// File: rtl/tsb_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter.
package tsb_pkg;

    typedef enum logic [1:0] {
        TSB_IDLE = 2'd0,
        TSB_OWN  = 2'd1,
        TSB_TURN = 2'd2
    } tsb_state_e;

    localparam int TSB_N_REQ_MIN = 2;
    localparam int TSB_N_REQ_MAX = 16;

    // owner_id width; never below one bit
    function automatic int tsb_id_w(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

    // width of a counter that must hold the value max_val (turn and hold counters)
    function automatic int tsb_cnt_w(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping modulo N_REQ.
module rr_picker
    import tsb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = tsb_id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] pick,
    output logic [ID_W-1:0]  pick_idx,
    output logic             pick_any
);

    int j;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        j        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!pick_any && req[j]) begin
                pick_any = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with enforced float (turnaround) cycles.
// Optional tenure cap enabled by defining TSB_HOLD_LIMIT_EN.
module tristate_bus_arbiter
    import tsb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         drv_en,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     bus_idle
);

    localparam int ID_W   = $clog2(N_REQ);
    localparam int TURN_W = tsb_cnt_w(TURNAROUND);

    tsb_state_e        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [TURN_W-1:0] turn_cnt;
    logic [N_REQ-1:0]  pick;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic              do_grant;
    logic              release_now;
    logic              hold_hit;
    logic [ID_W-1:0]   ptr_after_owner;

    rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_picker (
        .req      (req),
        .ptr      (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

`ifdef TSB_HOLD_LIMIT_EN
    localparam int HOLD_W = tsb_cnt_w(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt;
    assign hold_hit = (hold_cnt == HOLD_W'(MAX_HOLD)) && ((req & ~gnt) != '0);
`else
    assign hold_hit = 1'b0;
`endif

    // Handshake: req is a level held for the whole tenure; gnt (== drv_en) follows one edge
    // after an arbitration edge and drops on the edge that samples req low (or a forced release).
    always_comb begin
        do_grant    = 1'b0;
        release_now = 1'b0;
        if (state == TSB_IDLE) do_grant = pick_any;
        if (state == TSB_TURN && turn_cnt <= TURN_W'(1)) do_grant = pick_any;
        if (state == TSB_OWN) release_now = !req[owner_id] || hold_hit;
    end

    assign ptr_after_owner = (int'(owner_id) == N_REQ - 1) ? '0 : owner_id + 1'b1;
    assign drv_en          = gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= TSB_IDLE;
            gnt      <= '0;
            owner_id <= '0;
            bus_idle <= 1'b1;
            rr_ptr   <= '0;
            turn_cnt <= '0;
`ifdef TSB_HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
        end else if (do_grant) begin
            state    <= TSB_OWN;
            gnt      <= pick;
            owner_id <= pick_idx;
            bus_idle <= 1'b0;
`ifdef TSB_HOLD_LIMIT_EN
            hold_cnt <= HOLD_W'(1);
`endif
        end else begin
            case (state)
                TSB_OWN: begin
                    if (release_now) begin
                        state    <= TSB_TURN;
                        gnt      <= '0;
                        bus_idle <= 1'b1;
                        rr_ptr   <= ptr_after_owner;
                        turn_cnt <= TURN_W'(TURNAROUND);
                    end
`ifdef TSB_HOLD_LIMIT_EN
                    // saturates while nobody else is waiting, so the tenure simply continues
                    else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                TSB_TURN: begin
                    if (turn_cnt <= TURN_W'(1)) state <= TSB_IDLE;
                    else turn_cnt <= turn_cnt - 1'b1;
                end
                default: state <= TSB_IDLE;
            endcase
        end
    end

endmodule
